// File: rtl/dccm_arbiter_if.sv
// Requester-side handshake bundle for dccm_arbiter.
// One instance per requester: the core load/store path and the loader/DMA port.
// The master modport is the requester's view; the slave modport is the arbiter's view.
interface dccm_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/dccm_arbiter.sv
// dccm_arbiter: shares one DCCM macro between the core (m0) and a loader/DMA port (m1).
// A read and a write to different words are dual-issued in the same cycle; every other
// overlap is contention and is resolved round-robin on last_gnt.
// Build option: define DCCM_ARB_FIXED_PRIO_EN to make m0 win every contention
// (last_gnt is then removed and m1 can starve).
// Read responses are tracked by an RD_LAT-deep {valid, id} pipeline (RD_LAT legal 1..4).
module dccm_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  dccm_arbiter_if.slave m0,
  dccm_arbiter_if.slave m1,
  output logic          dccm_wr_en,
  output logic [AW-1:0] dccm_wr_addr,
  output logic [DW-1:0] dccm_wr_data,
  output logic          dccm_rd_en,
  output logic [AW-1:0] dccm_rd_addr,
  input  logic [DW-1:0] dccm_rd_data
);

  logic              w_both;
  logic              w_same_word;
  logic              w_dual;
  logic              w_cont;
  logic              w_m0_wins;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_rd0;
  logic              w_rd1;
  logic              w_wr0;
  logic              w_wr1;
  logic              w_out_vld;
  logic              w_out_id;
  logic [RD_LAT-1:0] r_vld;
  logic [RD_LAT-1:0] r_id;

  // Only the word address matters for a collision; byte offsets within a word collide too.
  assign w_both      = m0.req & m1.req;
  assign w_same_word = (m0.addr[AW-1:2] == m1.addr[AW-1:2]);
  assign w_dual      = w_both & (m0.we ^ m1.we) & ~w_same_word;
  assign w_cont      = w_both & ~w_dual;

`ifdef DCCM_ARB_FIXED_PRIO_EN
  assign w_m0_wins = 1'b1;
`else
  // r_last_gnt: 0 = m0 won the last contention, 1 = m1 did. Reset to m1 so m0 wins first.
  logic r_last_gnt;

  // Record the contention winner; dual-issue and single-requester cycles leave it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_gnt <= 1'b1;
    end else if (w_cont) begin
      r_last_gnt <= ~w_m0_wins;
    end
  end

  assign w_m0_wins = r_last_gnt;
`endif

  // Grant decision; forced low while reset is asserted so nothing issues in a reset cycle.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (rst_n) begin
      if (w_dual) begin
        w_gnt0 = 1'b1;
        w_gnt1 = 1'b1;
      end else if (w_cont) begin
        w_gnt0 = w_m0_wins;
        w_gnt1 = ~w_m0_wins;
      end else begin
        w_gnt0 = m0.req;
        w_gnt1 = m1.req;
      end
    end
  end

  assign w_rd0 = w_gnt0 & ~m0.we;
  assign w_rd1 = w_gnt1 & ~m1.we;
  assign w_wr0 = w_gnt0 &  m0.we;
  assign w_wr1 = w_gnt1 &  m1.we;

  // Steer the granted requester(s) onto the DCCM ports; unused fields are held at zero.
  always_comb begin
    dccm_rd_en   = 1'b0;
    dccm_rd_addr = '0;
    dccm_wr_en   = 1'b0;
    dccm_wr_addr = '0;
    dccm_wr_data = '0;
    if (w_rd0) begin
      dccm_rd_en   = 1'b1;
      dccm_rd_addr = m0.addr;
    end else if (w_rd1) begin
      dccm_rd_en   = 1'b1;
      dccm_rd_addr = m1.addr;
    end
    if (w_wr0) begin
      dccm_wr_en   = 1'b1;
      dccm_wr_addr = m0.addr;
      dccm_wr_data = m0.wdata;
    end else if (w_wr1) begin
      dccm_wr_en   = 1'b1;
      dccm_wr_addr = m1.addr;
      dccm_wr_data = m1.wdata;
    end
  end

  // Shift {valid, id} of each issued read so it lines up with dccm_rd_data RD_LAT cycles later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_id  <= '0;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
        r_vld[i] <= r_vld[i-1];
        r_id[i]  <= r_id[i-1];
      end
      r_vld[0] <= dccm_rd_en;
      r_id[0]  <= w_rd1;
    end
  end

  assign w_out_vld = r_vld[RD_LAT-1];
  assign w_out_id  = r_id[RD_LAT-1];

  assign m0.gnt    = w_gnt0;
  assign m1.gnt    = w_gnt1;
  assign m0.rvalid = w_out_vld & ~w_out_id;
  assign m1.rvalid = w_out_vld &  w_out_id;
  assign m0.rdata  = (w_out_vld & ~w_out_id) ? dccm_rd_data : '0;
  assign m1.rdata  = (w_out_vld &  w_out_id) ? dccm_rd_data : '0;

endmodule

// File: tb/tb_dccm_arbiter.sv
// Bench for dccm_arbiter: four DUTs (RD_LAT = 1..4) share one stimulus stream, each with
// its own DCCM model preloaded with data = byte address.
module tb_dccm_arbiter;

`ifdef DCCM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        s0_req, s0_we, s1_req, s1_we;
  logic [31:0] s0_addr, s0_wdata, s1_addr, s1_wdata;

  logic [3:0]  o_gnt0, o_gnt1, o_rv0, o_rv1, o_rden, o_wren;
  logic [31:0] o_rd0 [4];
  logic [31:0] o_rd1 [4];
  logic [31:0] o_rdaddr [4];
  logic [31:0] o_wraddr [4];
  logic [31:0] o_wrdata [4];

  for (genvar g = 0; g < 4; g++) begin : g_lat
    dccm_arbiter_if #(.AW(32), .DW(32)) m0_if ();
    dccm_arbiter_if #(.AW(32), .DW(32)) m1_if ();
    logic        wr_en, rd_en;
    logic [31:0] wr_addr, wr_data, rd_addr, rd_data;
    logic [31:0] mem [0:255];
    logic [31:0] pipe [0:3];

    assign m0_if.req   = s0_req;
    assign m0_if.we    = s0_we;
    assign m0_if.addr  = s0_addr;
    assign m0_if.wdata = s0_wdata;
    assign m1_if.req   = s1_req;
    assign m1_if.we    = s1_we;
    assign m1_if.addr  = s1_addr;
    assign m1_if.wdata = s1_wdata;

    dccm_arbiter #(.AW(32), .DW(32), .RD_LAT(g + 1)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .m0           (m0_if),
      .m1           (m1_if),
      .dccm_wr_en   (wr_en),
      .dccm_wr_addr (wr_addr),
      .dccm_wr_data (wr_data),
      .dccm_rd_en   (rd_en),
      .dccm_rd_addr (rd_addr),
      .dccm_rd_data (rd_data)
    );

    initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'(i * 4);
      for (int i = 0; i < 4; i++) pipe[i] = 32'h0;
    end

    // DCCM model: read samples the array before a same-edge write lands.
    always @(posedge clk) begin
      pipe[0] <= rd_en ? mem[rd_addr[9:2]] : 32'h0;
      for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
      if (wr_en) mem[wr_addr[9:2]] <= wr_data;
    end
    assign rd_data = pipe[g];

    assign o_gnt0[g]   = m0_if.gnt;
    assign o_gnt1[g]   = m1_if.gnt;
    assign o_rv0[g]    = m0_if.rvalid;
    assign o_rv1[g]    = m1_if.rvalid;
    assign o_rd0[g]    = m0_if.rdata;
    assign o_rd1[g]    = m1_if.rdata;
    assign o_rden[g]   = rd_en;
    assign o_wren[g]   = wr_en;
    assign o_rdaddr[g] = rd_addr;
    assign o_wraddr[g] = wr_addr;
    assign o_wrdata[g] = wr_data;
  end

  typedef struct {
    logic        m0_req;
    logic        m0_we;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic        m1_req;
    logic        m1_we;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic [1:0]  e_gnt;
    logic        e_rd_en;
    logic [31:0] e_rd_addr;
    logic        e_wr_en;
    logic [31:0] e_wr_addr;
    logic [31:0] e_wr_data;
    logic [1:0]  e_rv;
    logic [31:0] e_rd0;
    logic [31:0] e_rd1;
  } vec_t;

  vec_t tv [10];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input int idx, input logic [191:0] got, input logic [191:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] got=%0h exp=%0h", nm, idx, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    s0_req = 1'b0; s0_we = 1'b0; s0_addr = 32'h0; s0_wdata = 32'h0;
    s1_req = 1'b0; s1_we = 1'b0; s1_addr = 32'h0; s1_wdata = 32'h0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_in();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic drv(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                     input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
    s0_req = r0; s0_we = w0; s0_addr = a0; s0_wdata = d0;
    s1_req = r1; s1_we = w1; s1_addr = a1; s1_wdata = d1;
  endtask

  logic exp_g0 [6];

  initial begin
    idle_in();

    tv[0] = '{1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0,
              2'b00,1'b0,32'h0,1'b0,32'h0,32'h0, 2'b00,32'h0,32'h0};
    tv[1] = '{1'b1,1'b0,32'h100,32'h0, 1'b1,1'b1,32'h200,32'hA5A5,
              2'b11,1'b1,32'h100,1'b1,32'h200,32'hA5A5, 2'b00,32'h0,32'h0};
    tv[2] = '{1'b0,1'b0,32'h0,32'h0, 1'b1,1'b0,32'h008,32'h0,
              2'b01,1'b1,32'h008,1'b0,32'h0,32'h0, 2'b10,32'h100,32'h0};
    tv[3] = '{1'b1,1'b1,32'h00C,32'h1111, 1'b0,1'b0,32'h0,32'h0,
              2'b10,1'b0,32'h0,1'b1,32'h00C,32'h1111, 2'b01,32'h0,32'h008};
    tv[4] = '{1'b1,1'b0,32'h010,32'h0, 1'b1,1'b0,32'h014,32'h0,
              2'b10,1'b1,32'h010,1'b0,32'h0,32'h0, 2'b00,32'h0,32'h0};
    tv[5] = '{1'b0,1'b0,32'h0,32'h0, 1'b1,1'b0,32'h200,32'h0,
              2'b01,1'b1,32'h200,1'b0,32'h0,32'h0, 2'b10,32'h010,32'h0};
    tv[6] = '{1'b1,1'b1,32'h020,32'h22, 1'b1,1'b1,32'h024,32'h33,
              (FIXED ? 2'b10 : 2'b01),1'b0,32'h0,1'b1,
              (FIXED ? 32'h020 : 32'h024),(FIXED ? 32'h22 : 32'h33), 2'b01,32'h0,32'hA5A5};
    tv[7] = '{1'b1,1'b0,32'h104,32'h0, 1'b1,1'b1,32'h104,32'h77,
              2'b10,1'b1,32'h104,1'b0,32'h0,32'h0, 2'b00,32'h0,32'h0};
    tv[8] = '{1'b1,1'b0,32'h044,32'h0, 1'b1,1'b1,32'h048,32'h99,
              2'b11,1'b1,32'h044,1'b1,32'h048,32'h99, 2'b10,32'h104,32'h0};
    tv[9] = '{1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0,
              2'b00,1'b0,32'h0,1'b0,32'h0,32'h0, 2'b10,32'h044,32'h0};

    // Table: combinational command outputs and RD_LAT=1 responses, one vector per cycle.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drv(tv[i].m0_req, tv[i].m0_we, tv[i].m0_addr, tv[i].m0_wdata,
          tv[i].m1_req, tv[i].m1_we, tv[i].m1_addr, tv[i].m1_wdata);
      @(negedge clk);
      chk("vec", i,
          192'({o_gnt0[0], o_gnt1[0], o_rden[0], o_rdaddr[0], o_wren[0], o_wraddr[0], o_wrdata[0],
                o_rv0[0], o_rv1[0], o_rd0[0], o_rd1[0]}),
          192'({tv[i].e_gnt, tv[i].e_rd_en, tv[i].e_rd_addr, tv[i].e_wr_en, tv[i].e_wr_addr,
                tv[i].e_wr_data, tv[i].e_rv, tv[i].e_rd0, tv[i].e_rd1}));
      tick();
    end

    // Same-word conflict out of reset: m0 read first (old data), then m1 write, then m0 sees new data.
    do_reset();
    drv(1'b1, 1'b0, 32'h104, 32'h0, 1'b1, 1'b1, 32'h104, 32'hCAFE);
    @(negedge clk);
    chk("conf_gnt_a", 0, 192'({o_gnt0[0], o_gnt1[0], o_rden[0], o_rdaddr[0]}), 192'({2'b10, 1'b1, 32'h104}));
    tick();
    drv(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h104, 32'hCAFE);
    @(negedge clk);
    chk("conf_gnt_b", 1, 192'({o_gnt0[0], o_gnt1[0], o_wren[0], o_wraddr[0], o_wrdata[0]}),
        192'({2'b01, 1'b1, 32'h104, 32'hCAFE}));
    chk("conf_old", 1, 192'({o_rv0[0], o_rd0[0]}), 192'({1'b1, 32'h104}));
    tick();
    drv(1'b1, 1'b0, 32'h104, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("conf_gnt_c", 2, 192'({o_gnt0[0], o_gnt1[0]}), 192'(2'b10));
    tick();
    idle_in();
    @(negedge clk);
    chk("conf_new", 3, 192'({o_rv0[0], o_rv1[0], o_rd0[0]}), 192'({2'b10, 32'hCAFE}));
    tick();

    // Back-to-back read contention for 6 cycles; responses follow grant order one cycle later.
    do_reset();
    for (int k = 0; k < 6; k++) exp_g0[k] = FIXED ? 1'b1 : (k % 2 == 0);
    for (int k = 0; k < 7; k++) begin
      if (k < 6) drv(1'b1, 1'b0, 32'h050, 32'h0, 1'b1, 1'b0, 32'h060, 32'h0);
      else idle_in();
      @(negedge clk);
      if (k < 6)
        chk("rr_gnt", k, 192'({o_gnt0[0], o_gnt1[0]}), 192'({exp_g0[k], ~exp_g0[k]}));
      if (k > 0)
        chk("rr_rsp", k, 192'({o_rv0[0], o_rv1[0], o_rd0[0], o_rd1[0]}),
            192'({exp_g0[k-1], ~exp_g0[k-1], exp_g0[k-1] ? 32'h050 : 32'h0, exp_g0[k-1] ? 32'h0 : 32'h060}));
      tick();
    end

    // Continuous write contention for 5 cycles, then m0 drops and m1 must be granted.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drv((k < 5), 1'b1, 32'h070, 32'h1234, 1'b1, 1'b1, 32'h074, 32'h5678);
      @(negedge clk);
      if (k < 5)
        chk("wr_cont", k, 192'({o_gnt0[0], o_gnt1[0], o_wraddr[0]}),
            192'(FIXED ? {2'b10, 32'h070} : ((k % 2 == 0) ? {2'b10, 32'h070} : {2'b01, 32'h074})));
      else
        chk("wr_drop", k, 192'({o_gnt0[0], o_gnt1[0], o_wraddr[0], o_wrdata[0]}),
            192'({2'b01, 32'h074, 32'h5678}));
      tick();
    end

    // Latency sweep: m1 reads 0x80..0x8C back-to-back, each DUT returns data after its RD_LAT.
    do_reset();
    for (int c = 0; c < 10; c++) begin
      if (c < 4) drv(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'(32'h80 + 4 * c), 32'h0);
      else idle_in();
      @(negedge clk);
      for (int g = 0; g < 4; g++) begin
        automatic int  kk = c - (g + 1);
        automatic logic ev = (kk >= 0) && (kk < 4);
        chk("lat", g * 16 + c, 192'({o_gnt1[g], o_rv0[g], o_rv1[g], o_rd1[g]}),
            192'({(c < 4), 1'b0, ev, ev ? 32'(32'h80 + 4 * kk) : 32'h0}));
      end
      tick();
    end

    // Reset with three reads in flight on the RD_LAT=3 DUT: nothing may come back.
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drv(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'(32'h90 + 4 * c), 32'h0);
      @(negedge clk);
      chk("rst_issue", c, 192'({o_gnt1[2], o_rden[2]}), 192'(2'b11));
      tick();
    end
    rst_n = 1'b0;
    drv(1'b1, 1'b0, 32'h0A0, 32'h0, 1'b1, 1'b1, 32'h0A4, 32'hFFFF);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      for (int g = 0; g < 4; g++)
        chk("rst_out", g * 4 + c,
            192'({o_gnt0[g], o_gnt1[g], o_rden[g], o_wren[g], o_rv0[g], o_rv1[g], o_rdaddr[g],
                  o_wraddr[g], o_wrdata[g], o_rd0[g], o_rd1[g]}),
            192'(0));
      tick();
    end
    idle_in();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("rst_norsp", c, 192'({o_rv0, o_rv1}), 192'(0));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
